bht_predictor: RTL
==================

BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning table index width (2**IDX_W entries, legal range 2..8).
REQ-002 SHALL have parameter CNT_W, default 2, meaning saturating-counter width per entry (legal 1..4).
REQ-003 SHALL have parameter INIT, default 2**(CNT_W-1), meaning counter value after reset (weakly taken at default).
REQ-004 SHALL have parameter GSHARE, default 0, meaning 0 = direct index and 1 = index XOR global history.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port lk_valid, input, 1, lookup request this cycle.
REQ-008 SHALL have port lk_pc, input, IDX_W, low PC bits of the branch being looked up.
REQ-009 SHALL have port pred_valid, output, 1, prediction valid (registered).
REQ-010 SHALL have port pred_taken, output, 1, predicted direction (1 = taken).
REQ-011 SHALL have port pred_idx, output, IDX_W, table index used, returned by the pipeline on update.
REQ-012 SHALL have port upd_valid, input, 1, branch resolved this cycle.
REQ-013 SHALL have port upd_idx, input, IDX_W, index to train (the pred_idx of that branch).
REQ-014 SHALL have port upd_taken, input, 1, actual outcome.
REQ-015 SHALL have port upd_mispred, input, 1, prediction was wrong (qualified by upd_valid).
REQ-016 SHALL have port ghr, output, IDX_W, global history register (all-zero and unused when GSHARE=0).
REQ-017 SHALL have port mispred_cnt, output, 16, saturating mispredict count.

Function
REQ-018 SHALL hold 2**IDX_W counters of CNT_W bits each.
REQ-019 SHALL form the lookup index as lk_pc when GSHARE=0, and as lk_pc XOR ghr when GSHARE=1.
REQ-020 SHALL register lookups with one-cycle latency: on an edge with lk_valid=1, pred_valid<=1, pred_idx<=index, pred_taken<=MSB of that counter as it was before that edge.
REQ-021 SHALL set pred_valid<=0 on an edge with lk_valid=0, holding pred_taken and pred_idx unchanged.
REQ-022 SHALL, on upd_valid=1, increment counter[upd_idx] when upd_taken=1, saturating at 2**CNT_W-1.
REQ-023 SHALL, on upd_valid=1, decrement counter[upd_idx] when upd_taken=0, saturating at 0.
REQ-024 SHALL, when a lookup and an update target the same entry in the same cycle, give the lookup the pre-update counter value (no bypass); the update still takes effect.
REQ-025 SHALL, with GSHARE=1 and upd_valid=1, shift ghr left by one, inserting upd_taken at bit 0 and discarding the MSB.
REQ-026 SHALL form the index of a simultaneous lookup from the pre-shift ghr.
REQ-027 SHALL increment mispred_cnt on upd_valid & upd_mispred, saturating at 16'hFFFF with no wrap.
REQ-028 SHALL ignore upd_taken and upd_mispred when upd_valid=0, changing no state.
REQ-029 SHALL accept back-to-back lookups and updates every cycle with no stall or ready signal.

Reset
REQ-030 SHALL, on rst_n low, immediately and asynchronously set all counters to INIT, ghr=0, mispred_cnt=0, pred_valid=0, pred_taken=0, pred_idx=0.
REQ-031 SHALL discard any in-flight lookup or update when reset asserts mid-operation; the first legal lookup after release SHALL use post-reset state.

Verification
REQ-032 SHALL pass: reset, then lookup lk_pc=5 -> next cycle pred_valid=1, pred_taken=1, pred_idx=5 (INIT=2).
REQ-033 SHALL pass: three updates idx=3 taken=0 -> counter 2->1->0->0 (saturate at 0), and a lookup of pc 3 gives pred_taken=0.
REQ-034 SHALL pass: four updates idx=3 taken=1 from 0 -> counter reaches 3 and holds, and pred_taken=1.
REQ-035 SHALL pass: same-cycle lookup pc=7 and update idx=7 taken=0 from counter 2 -> pred_taken=1 that cycle, and a following lookup gives 0.
REQ-036 SHALL pass, with GSHARE=1: updates taken 1,0,1 -> ghr=4'b0101, and lookup lk_pc=4'b0110 -> pred_idx=4'b0011.
REQ-037 SHALL pass: 65540 mispredict updates -> mispred_cnt=16'hFFFF; then rst_n pulsed low mid-cycle -> all outputs zero before the next clock edge.

Source files
------------

// File: rtl/bht_predictor.sv
// Branch history table of saturating counters with optional gshare indexing.
// Lookups return a registered prediction one cycle later; updates train one counter per cycle.
module bht_predictor #(
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 2,
    parameter int INIT   = 2 ** (CNT_W - 1),
    parameter int GSHARE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             upd_mispred,
    output logic [IDX_W-1:0] ghr,
    output logic [15:0]      mispred_cnt
);

    localparam int               ENTRIES  = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT);

    logic [CNT_W-1:0] cnt_q [ENTRIES];
    logic [CNT_W-1:0] cnt_d [ENTRIES];
    logic [CNT_W-1:0] upd_cnt;
    logic [IDX_W-1:0] lk_idx;

    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [IDX_W-1:0] pred_idx_q,   pred_idx_d;
    logic [IDX_W-1:0] ghr_q,        ghr_d;
    logic [15:0]      mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        // Index uses the pre-shift history even when an update shifts it this cycle.
        lk_idx = (GSHARE != 0) ? (lk_pc ^ ghr_q) : lk_pc;

        // Lookup reads cnt_q, so a same-cycle update to that entry is not bypassed.
        pred_valid_d = lk_valid;
        pred_taken_d = lk_valid ? cnt_q[lk_idx][CNT_W-1] : pred_taken_q;
        pred_idx_d   = lk_valid ? lk_idx : pred_idx_q;

        cnt_d         = cnt_q;
        upd_cnt       = cnt_q[upd_idx];
        ghr_d         = ghr_q;
        mispred_cnt_d = mispred_cnt_q;

        if (upd_valid) begin
            if (upd_taken) begin
                if (upd_cnt != CNT_MAX) cnt_d[upd_idx] = upd_cnt + CNT_ONE;
            end else begin
                if (upd_cnt != '0) cnt_d[upd_idx] = upd_cnt - CNT_ONE;
            end
            if (GSHARE != 0) ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
            if (upd_mispred && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is a register array, not RAM, so every entry can be reset to INIT.
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_idx_q    <= '0;
            ghr_q         <= '0;
            mispred_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            cnt_q         <= cnt_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_idx_q    <= pred_idx_d;
            ghr_q         <= ghr_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_taken  = pred_taken_q;
    assign pred_idx    = pred_idx_q;
    assign ghr         = ghr_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
